keyboard_controller: RTL

//  PS/2 keyboard receiver: the device end of the keyboard port read by the address decoder
//  (0x80003000 = scancode, 0x80003001 = valid flag).

---
 rtl/keyboard_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/keyboard_controller.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, checks framing and odd parity, and holds scancodes for the CPU.
// Define KBD_FIFO_EN to use a FIFO_DEPTH-entry scancode FIFO instead of the single holding register.
module keyboard_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       keyboard_readed_signal,
  output logic [7:0] keyboard_data,
  output logic       keyboard_valid_data,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic        clk_s1, clk_s2, clk_prev;
  logic        data_s1, data_s2;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        parity_bit;
  logic [TO_W-1:0] to_cnt;
  logic        commit;
  logic [7:0]  commit_byte;
  logic        readed_prev;
  logic        fall;
  logic        pop;

  assign fall = clk_prev & ~clk_s2;
  assign pop  = keyboard_readed_signal & ~readed_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_prev    <= 1'b1;
      data_s1     <= 1'b1;
      data_s2     <= 1'b1;
      readed_prev <= 1'b0;
    end else begin
      clk_s1      <= ps2_clk;
      clk_s2      <= clk_s1;
      clk_prev    <= clk_s2;
      data_s1     <= ps2_data;
      data_s2     <= data_s1;
      readed_prev <= keyboard_readed_signal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      to_cnt      <= '0;
      commit      <= 1'b0;
      commit_byte <= '0;
      frame_error <= 1'b0;
    end else begin
      commit      <= 1'b0;
      frame_error <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (fall && !data_s2) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_s2;
            state      <= STOP;
          end
          default: begin
            state <= IDLE;
            if (data_s2 && (^{shift, parity_bit})) begin
              commit      <= 1'b1;
              commit_byte <= shift;
            end else begin
              frame_error <= 1'b1;
            end
          end
        endcase
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        // Stalled mid-frame: drop the partial byte and resynchronise on the next start bit.
        state       <= IDLE;
        to_cnt      <= '0;
        frame_error <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

`ifdef KBD_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty, full, pop_eff;

  assign empty               = (count == '0);
  assign full                = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop_eff             = pop & ~empty;
  assign keyboard_valid_data = ~empty;
  assign keyboard_data       = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      if (commit && (!full || pop_eff)) begin
        mem[wr_ptr] <= commit_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (commit && full && !pop_eff) overrun <= 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      if (commit && !full && !pop_eff) count <= count + 1'b1;
      else if (!commit && pop_eff)     count <= count - 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      keyboard_data       <= '0;
      keyboard_valid_data <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!keyboard_valid_data || pop) begin
          keyboard_data       <= commit_byte;
          keyboard_valid_data <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pop && keyboard_valid_data) begin
        keyboard_data       <= '0;
        keyboard_valid_data <= 1'b0;
      end
    end
  end
`endif

endmodule
